// File: rtl/conv_pkg.sv
// conv_pkg: state type and helpers shared by the conv controllers.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } cfc_state_t;

  // Keep-gate on the sign bit, so callers of any data width can apply it.
  function automatic logic relu(
    input logic sign,
    input logic en
  );
    return !(en && sign);
  endfunction

endpackage

// File: rtl/fmap_buffer.sv
// fmap_buffer: column-wide write, single-element registered read.
module fmap_buffer #(
  parameter int DW    = 32,
  parameter int LANES = 10,
  parameter int COLS  = 10,
  parameter int CW    = 4,
  parameter int RW    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_col,
  input  logic [LANES-1:0][DW-1:0]   wr_data,
  input  logic                       rd_en,
  input  logic [RW-1:0]              rd_row,
  input  logic [CW-1:0]              rd_col,
  output logic [DW-1:0]              rd_data
);

  logic [LANES-1:0][DW-1:0] mem [COLS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_col] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_col][rd_row];
    end
  end

endmodule

// File: rtl/conv_fmap_collector.sv
// conv_fmap_collector: captures conv columns into a feature map,
// then drains it row-major over a valid/ready stream.
module conv_fmap_collector
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 10,
  parameter int NUM_COLS   = 10,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 in_valid,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_data,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 done,
  output logic                                 err
);

  localparam int TOTAL = NUM_LANES * NUM_COLS;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(NUM_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(NUM_LANES - 1);
  localparam logic [IW-1:0] TOT     = IW'(TOTAL);
  localparam logic [IW-1:0] LAST    = IW'(TOTAL - 1);

  cfc_state_t state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [IW-1:0] idx;
  logic rd_v;
  logic rd_last;
  logic adv;
  logic wr_en;
  logic rd_en;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    wr_data = in_data;
    for (int r = 0; r < NUM_LANES; r++) begin
      wr_data[r] = in_data[r] &
        {DATA_WIDTH{relu(in_data[r][DATA_WIDTH-1], RELU_EN)}};
    end
  end

  // Read stage and output stage stall together, so no skid buffer is needed.
  assign adv   = (state == DRAIN) && (!out_valid || out_ready);
  assign wr_en = in_valid && in_ready;
  assign rd_en = adv && (idx != TOT);

  fmap_buffer #(
    .DW    (DATA_WIDTH),
    .LANES (NUM_LANES),
    .COLS  (NUM_COLS),
    .CW    (CW),
    .RW    (RW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_col  (col_cnt),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_cnt   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      idx       <= '0;
      rd_v      <= 1'b0;
      rd_last   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid && !in_ready) err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPTURE;
            col_cnt  <= '0;
            err      <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            if (col_cnt == COL_MAX) begin
              col_cnt  <= '0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (adv) begin
            out_valid <= rd_v;
            out_last  <= rd_last;
            out_data  <= rd_data;
            rd_v      <= (idx != TOT);
            rd_last   <= (idx == LAST);
            if (idx != TOT) begin
              idx <= idx + IW'(1);
              if (rd_col == COL_MAX) begin
                rd_col <= '0;
                rd_row <= (rd_row == ROW_MAX) ? '0 : rd_row + RW'(1);
              end else begin
                rd_col <= rd_col + CW'(1);
              end
            end
          end
          if (out_valid && out_ready && out_last) begin
            state     <= DONE;
            done      <= 1'b1;
            idx       <= '0;
            rd_v      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
